chip8_fetch: RTL

- CHIP-8 instruction fetch unit; the read-side initiator for the byte-wide `memory` block.
- Issues two sequential byte reads at PC and PC+1, then assembles a big-endian 16-bit opcode.
- Presents the opcode to the decoder with a valid/ready handshake.
- Owns the program counter: sequential advance, skip, and jump/flush load.

---
 rtl/chip8_fetch.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/chip8_fetch.sv
// chip8_fetch: CHIP-8 instruction fetch unit.
// Reads the two opcode bytes at pc and pc+1 from byte-wide memory, then
// offers the assembled big-endian opcode to the decoder through a
// valid/ready handshake. Also owns the program counter: it advances by
// 2 or 4 at each handshake and is loaded directly on a jump or flush.
//
// Optional feature, controlled by the macro CHIP8_FETCH_BOUNDS_CHECK_EN:
//   defined   - a fetch that would begin at pc = all-ones (so its second
//               byte would wrap to address 0) goes to a sticky FAULT state
//               and raises fault. Only reset or pc_load leaves FAULT.
//   undefined - there is no FAULT state, fault is tied low, and a fetch
//               at the top address simply wraps its second read to 0.

module chip8_fetch #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(12'h200)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_read_addr,
  input  logic [7:0]        mem_read_data,
  output logic [15:0]       opcode,
  output logic              opcode_valid,
  input  logic              opcode_ready,
  input  logic              pc_skip,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  output logic [ADDR_W-1:0] pc,
  output logic              fault
);

  // Fetch sequencer states. FAULT exists only with the bounds check.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_HI  = 3'd1,
    REQ_LO  = 3'd2,
    WAIT_LO = 3'd3,
`ifdef CHIP8_FETCH_BOUNDS_CHECK_EN
    VALID   = 3'd4,
    FAULT   = 3'd5
`else
    VALID   = 3'd4
`endif
  } fetch_state_t;

  fetch_state_t state;
  fetch_state_t state_next;
  fetch_state_t restart_state;

  logic              handshake;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_plus2;
  logic [ADDR_W-1:0] pc_plus4;

  // All pc arithmetic wraps naturally at the address width.
  assign pc_plus1  = pc + ADDR_W'(1);
  assign pc_plus2  = pc + ADDR_W'(2);
  assign pc_plus4  = pc + ADDR_W'(4);
  assign handshake = opcode_valid & opcode_ready;

  // Next pc: a load beats a handshake; a skip only matters at a handshake.
  always_comb begin
    pc_next = pc;
    if (pc_load) begin
      pc_next = pc_load_value;
    end else if (handshake) begin
      pc_next = pc_skip ? pc_plus4 : pc_plus2;
    end
  end

  // Where a new fetch starts from: idle when disabled, otherwise a read of
  // the high byte (or FAULT when that fetch would straddle the top address).
  always_comb begin
    restart_state = IDLE;
    if (enable) begin
      restart_state = REQ_HI;
`ifdef CHIP8_FETCH_BOUNDS_CHECK_EN
      if (pc_next == {ADDR_W{1'b1}}) begin
        restart_state = FAULT;
      end
`endif
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; pc_load flushes any fetch (and FAULT) from any state.
  always_comb begin
    state_next = state;
    if (pc_load) begin
      state_next = restart_state;
    end else begin
      case (state)
        IDLE:    if (enable) state_next = restart_state;
        REQ_HI:  state_next = REQ_LO;
        REQ_LO:  state_next = WAIT_LO;
        WAIT_LO: state_next = VALID;
        VALID:   if (opcode_ready) state_next = restart_state;
`ifdef CHIP8_FETCH_BOUNDS_CHECK_EN
        FAULT:   state_next = FAULT;
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  // Memory strobe, read address, handshake valid and fault, decoded from state.
  always_comb begin
    mem_read      = 1'b0;
    mem_read_addr = pc;
    opcode_valid  = 1'b0;
    fault         = 1'b0;
    case (state)
      REQ_HI: begin
        mem_read = 1'b1;
      end
      REQ_LO: begin
        mem_read      = 1'b1;
        mem_read_addr = pc_plus1;
      end
      VALID: begin
        opcode_valid = 1'b1;
      end
`ifdef CHIP8_FETCH_BOUNDS_CHECK_EN
      FAULT: begin
        fault = 1'b1;
      end
`endif
      default: begin
        mem_read = 1'b0;
      end
    endcase
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_RESET;
    end else begin
      pc <= pc_next;
    end
  end

  // Opcode assembly: memory returns data one cycle after the strobe, so the
  // high byte lands during REQ_LO and the low byte during WAIT_LO. A flush
  // drops the capture, and opcode is only ever offered from VALID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode <= 16'h0000;
    end else if (!pc_load) begin
      if (state == REQ_LO) begin
        opcode[15:8] <= mem_read_data;
      end else if (state == WAIT_LO) begin
        opcode[7:0] <= mem_read_data;
      end
    end
  end

endmodule
